store_merge_buffer: RTL and testbench

STORE_MERGE_BUFFER -- requirements
Module: store_merge_buffer

---
 rtl/store_merge_buffer_pkg.sv | 17 +
 rtl/smb_fifo_ram.sv | 28 ++
 rtl/store_merge_buffer.sv | 97 +++++++++
 tb/tb_store_merge_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_buffer_pkg.sv
// Shared CPU package: store-buffer entry record and word-alignment constants.
package store_merge_buffer_pkg;

    localparam int unsigned WordAlignBits = 2;
    localparam logic [WordAlignBits-1:0] WordAlign = 2'b00;

    // One buffered store: word address plus full data word (62 bits).
    typedef struct packed {
        logic [29:0] addr_w;
        logic [31:0] data;
    } smb_entry_t;

    function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
        return byte_addr[31:WordAlignBits];
    endfunction

endpackage

// File: rtl/smb_fifo_ram.sv
// Entry storage for the store merge buffer: two write ports, one asynchronous read port.
module smb_fifo_ram
    import store_merge_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     we_a_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_a_i,
    input  smb_entry_t               wdata_a_i,
    input  logic                     we_b_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_b_i,
    input  smb_entry_t               wdata_b_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output smb_entry_t               rdata_o
);

    smb_entry_t mem_q [DEPTH];

    // Callers never present the same address on both write ports in one cycle.
    always_ff @(posedge clk_i) begin
        if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
        if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_merge_buffer.sv
// Dual-port store buffer: merges same-word double stores and drains in order to data memory.
module store_merge_buffer
    import store_merge_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        memwrite2,
    input  logic [31:0] dataadr2,
    input  logic [31:0] writedata2,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        overflow,
    output logic        misalign
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d, n_push;
    logic            overflow_q, overflow_d, misalign_q, misalign_d;

    logic            acc1, acc2, merge, enq1, enq2, pop;
    logic [PtrW-1:0] waddr_b;
    smb_entry_t      entry1, entry2, head;

    always_comb begin
        stall   = count_q > CntW'(DEPTH - 2);
        acc1    = memwrite & ~stall;
        acc2    = memwrite2 & ~stall;
        // Same-word double store collapses to port 2's entry only.
        merge   = acc1 & acc2 & (word_of(dataadr) == word_of(dataadr2));
        enq1    = acc1 & ~merge;
        enq2    = acc2;
        entry1  = '{addr_w: word_of(dataadr),  data: writedata};
        entry2  = '{addr_w: word_of(dataadr2), data: writedata2};
        waddr_b = wptr_q + PtrW'(enq1);
        pop     = (count_q != '0) & mem_ready;
        n_push  = CntW'(enq1) + CntW'(enq2);

        count_d    = count_q + n_push - CntW'(pop);
        wptr_d     = wptr_q + PtrW'(n_push);
        rptr_d     = rptr_q + PtrW'(pop);
        overflow_d = overflow_q | (stall & (memwrite | memwrite2));
        misalign_d = misalign_q
                   | (acc1 & (dataadr[WordAlignBits-1:0] != WordAlign))
                   | (acc2 & (dataadr2[WordAlignBits-1:0] != WordAlign));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
        end
    end

    smb_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (clk),
        .we_a_i    (enq1),
        .waddr_a_i (wptr_q),
        .wdata_a_i (entry1),
        .we_b_i    (enq2),
        .waddr_b_i (waddr_b),
        .wdata_b_i (entry2),
        .raddr_i   (rptr_q),
        .rdata_o   (head)
    );

    // Outputs depend on registered state only, so reset clears them immediately.
    always_comb begin
        mem_we    = count_q != '0;
        mem_addr  = mem_we ? {head.addr_w, WordAlign} : 32'h0;
        mem_wdata = mem_we ? head.data : 32'h0;
        overflow  = overflow_q;
        misalign  = misalign_q;
    end

endmodule

// File: tb/tb_store_merge_buffer.sv
// Self-checking bench for store_merge_buffer: queue-based reference model plus directed literals.
module tb_store_merge_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0, memwrite2 = 1'b0, mem_ready = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0, dataadr2 = '0, writedata2 = '0;
    logic        mem_we, stall, overflow, misalign;
    logic [31:0] mem_addr, mem_wdata;

    store_merge_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .memwrite2  (memwrite2),
        .dataadr2   (dataadr2),
        .writedata2 (writedata2),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (stall),
        .overflow   (overflow),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    function automatic ent_t mk(input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.addr = a & ~32'h3;
        e.data = d;
        return e;
    endfunction

    // Reference model: an ordered queue of pending stores and two sticky flags.
    ent_t mq[$];
    logic m_ovf = 1'b0, m_mis = 1'b0;
    int   m_pops = 0, dut_pops = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf  <= 1'b0;
            m_mis  <= 1'b0;
        end else begin
            if (mq.size() > DEPTH - 2) begin
                if (memwrite || memwrite2) m_ovf <= 1'b1;
                if (mem_ready) begin
                    void'(mq.pop_front());
                    m_pops <= m_pops + 1;
                end
            end else begin
                if (mq.size() > 0 && mem_ready) begin
                    void'(mq.pop_front());
                    m_pops <= m_pops + 1;
                end
                if (memwrite && memwrite2 && dataadr[31:2] == dataadr2[31:2]) begin
                    mq.push_back(mk(dataadr2, writedata2));
                end else begin
                    if (memwrite)  mq.push_back(mk(dataadr, writedata));
                    if (memwrite2) mq.push_back(mk(dataadr2, writedata2));
                end
                if ((memwrite && dataadr[1:0] != 2'b00) || (memwrite2 && dataadr2[1:0] != 2'b00))
                    m_mis <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && mem_we && mem_ready) dut_pops <= dut_pops + 1;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic        e_we;
        logic [31:0] e_addr, e_data;
        e_we   = mq.size() > 0;
        e_addr = e_we ? mq[0].addr : 32'h0;
        e_data = e_we ? mq[0].data : 32'h0;
        chk("model mem_we",    32'(mem_we),    32'(e_we));
        chk("model mem_addr",  mem_addr,       e_addr);
        chk("model mem_wdata", mem_wdata,      e_data);
        chk("model stall",     32'(stall),     32'(mq.size() > DEPTH - 2));
        chk("model overflow",  32'(overflow),  32'(m_ovf));
        chk("model misalign",  32'(misalign),  32'(m_mis));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) check_model();
    endtask

    task automatic idle();
        memwrite  = 1'b0;
        memwrite2 = 1'b0;
    endtask

    task automatic st1(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
    endtask

    task automatic st2(input logic [31:0] a, input logic [31:0] d);
        memwrite2  = 1'b1;
        dataadr2   = a;
        writedata2 = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int drain;
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        chk("reset mem_we", 32'(mem_we), 32'h0);
        chk("reset stall",  32'(stall),  32'h0);
        tick();

        // Single store, one-cycle latency, immediate drain.
        mem_ready = 1'b1;
        st1(32'h10, 32'hAAAA0001);
        tick();
        idle();
        chk("s1 mem_we",    32'(mem_we), 32'h1);
        chk("s1 mem_addr",  mem_addr,    32'h10);
        chk("s1 mem_wdata", mem_wdata,   32'hAAAA0001);
        tick();
        chk("s1 drained",   32'(mem_we), 32'h0);

        // Double store, ordered drain.
        mem_ready = 1'b0;
        st1(32'h20, 32'h1);
        st2(32'h24, 32'h2);
        tick();
        idle();
        chk("s2 head addr", mem_addr, 32'h20);
        chk("s2 stall",     32'(stall), 32'h0);
        tick();
        mem_ready = 1'b1;
        tick();
        chk("s2 2nd addr", mem_addr,  32'h24);
        chk("s2 2nd data", mem_wdata, 32'h2);
        tick();
        chk("s2 drained", 32'(mem_we), 32'h0);

        // Same-word merge: port 2 wins, one entry.
        mem_ready = 1'b0;
        st1(32'h30, 32'h5);
        st2(32'h30, 32'h9);
        tick();
        idle();
        chk("s3 addr", mem_addr,  32'h30);
        chk("s3 data", mem_wdata, 32'h9);
        mem_ready = 1'b1;
        tick();
        chk("s3 single entry", 32'(mem_we), 32'h0);

        // Fill to stall, then a dropped push.
        mem_ready = 1'b0;
        st1(32'h50, 32'h50);
        tick();
        chk("s4 stall@1", 32'(stall), 32'h0);
        st1(32'h54, 32'h54);
        tick();
        chk("s4 stall@2", 32'(stall), 32'h0);
        st1(32'h58, 32'h58);
        tick();
        chk("s4 stall@3", 32'(stall), 32'h1);
        st1(32'h5C, 32'h5C);
        tick();
        idle();
        chk("s4 overflow", 32'(overflow), 32'h1);
        chk("s4 stall kept", 32'(stall), 32'h1);
        mem_ready = 1'b1;
        tick();
        tick();
        chk("s4 last addr", mem_addr, 32'h58);
        tick();
        chk("s4 count was 3", 32'(mem_we), 32'h0);

        // Misaligned store, then reset between edges.
        mem_ready = 1'b0;
        st1(32'h43, 32'h77);
        tick();
        idle();
        chk("s5 aligned addr", mem_addr, 32'h40);
        chk("s5 misalign",     32'(misalign), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("s5 rst mem_we",   32'(mem_we),   32'h0);
        chk("s5 rst mem_addr", mem_addr,      32'h0);
        chk("s5 rst misalign", 32'(misalign), 32'h0);
        chk("s5 rst overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("s5 no write after reset", 32'(mem_we), 32'h0);

        // Random pushes/pops with pointer wrap, checked against the model each cycle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            memwrite   = 1'($urandom_range(0, 1));
            memwrite2  = 1'($urandom_range(0, 1));
            dataadr    = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            dataadr2   = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            writedata  = $urandom;
            writedata2 = $urandom;
            mem_ready  = 1'($urandom_range(0, 1));
            tick();
        end
        idle();
        mem_ready = 1'b1;
        drain = 0;
        while (mq.size() > 0 && drain < 10) begin
            tick();
            drain++;
        end
        chk("rand drain done", 32'(mq.size()), 32'h0);
        chk("rand pop count",  32'(dut_pops), 32'(m_pops));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
